game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
Top-level phase controller for the shooting game core. Debounces the raw start button and counts frames from the VGA vsync. Sequences the game through attract, play, hit-recovery and game-over phases, gating the game engine and tracking lives and score. Sits between the pad inputs and main, in the same clk/rst domain as main.

Parameters:
LIVES, 3, lives loaded at game start (1..7)
SCORE_W, 16, score counter width
DEBOUNCE_CYCLES, 1000, consecutive stable cycles needed to accept a new start_btn level (>=2)
HIT_FRAMES, 60, frame ticks spent in HIT before resuming play (>=1)
OVER_FRAMES, 180, frame ticks spent in OVER before returning to ATTRACT (>=1)

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  asynchronous, active-high reset
start_btn  input  1  raw start button from pad, asynchronous to clk, active-high
vsync  input  1  VGA vsync from timing generator, synchronous to clk, active-low pulse
hit_player  input  1  one-cycle pulse: player struck
hit_enemy  input  1  one-cycle pulse: enemy destroyed
phase  output  2  0=ATTRACT, 1=PLAY, 2=HIT, 3=OVER
game_en  output  1  high only in PLAY; enables object motion in the engine
clear_field  output  1  one-cycle pulse: engine reinitialises object positions
lives  output  3  remaining lives
score  output  SCORE_W  enemies destroyed this game
game_over  output  1  high in OVER

Behaviour:
- Reset (async, active-high) forces: phase=ATTRACT, game_en=0, clear_field=0, lives=LIVES, score=0, game_over=0, frame counter=0, debounce state=released, sync flops=0.
- start_btn path: 2-flop synchroniser, then debounce counter. The counter resets whenever the synced level equals the debounced level. When it reaches DEBOUNCE_CYCLES, the debounced level flips. start_press is a one-cycle pulse on the debounced 0->1 edge, registered. Release edges produce nothing.
- frame_tick: one-cycle pulse when vsync transitions 0->1 (end of sync pulse), detected with a single delay register. Reset value of that register is 1.
- All outputs are registered; the state change and output update occur on the clk edge after the triggering pulse is sampled.
- ATTRACT:
  - start_press -> PLAY; lives<=LIVES; score<=0; clear_field pulses 1 cycle.
  - hit_* ignored.
- PLAY:
  - game_en=1.
  - hit_enemy -> score+1, saturating at all-ones (no wrap).
  - hit_player with lives>1 -> lives-1, go to HIT, frame counter cleared.
  - hit_player with lives==1 -> lives=0, go to OVER, frame counter cleared.
  - Simultaneous hit_enemy and hit_player: both applied in the same edge (score increments and life is lost).
  - start_press ignored (unless SEQ_PAUSE_EN).
- HIT:
  - game_en=0; hit_* and start_press ignored.
  - Frame counter increments per frame_tick.
  - On the tick that makes the count equal HIT_FRAMES -> PLAY with a clear_field pulse; counter cleared.
- OVER:
  - game_over=1, game_en=0; score and lives held; start_press and hit_* ignored.
  - After OVER_FRAMES ticks -> ATTRACT, counter cleared. score remains visible in ATTRACT until the next game start.
- Frame counter width is clog2(max(HIT_FRAMES, OVER_FRAMES)+1). Counting applies only in HIT and OVER.
- Reset asserted mid-game returns to the reset state immediately and asynchronously; no clear_field is issued.

Optional Feature:
SEQ_PAUSE_EN:
- Defined: adds a PAUSE state, encoded by reusing phase=2 with game_en=0 and an internal flag. Encoding phase=2 with pause distinguished only internally is acceptable.
- start_press in PLAY -> PAUSE; start_press in PAUSE -> PLAY, with no clear_field.
- In PAUSE, hit_* are ignored and frame ticks are not counted.
- Undefined: no PAUSE state; start_press in PLAY is ignored.

Test Plan:
- Params DEBOUNCE_CYCLES=4, HIT_FRAMES=2, OVER_FRAMES=3, LIVES=2 for all scenarios.
- Reset then start_btn high 10 cycles -> exactly one clear_field pulse; phase 0->1; lives=2; score=0; game_en=1. A 3-cycle glitch on start_btn -> no transition.
- In PLAY, 5 hit_enemy pulses -> score=5. With SCORE_W=3, 9 pulses -> score saturates at 7.
- hit_player in PLAY -> phase=2, lives=1, game_en=0. 2 vsync rising edges -> phase=1 plus clear_field pulse. hit_enemy during HIT -> score unchanged.
- hit_player and hit_enemy in the same cycle with lives=1 -> lives=0, score+1, phase=3, game_over=1. 3 frame ticks -> phase=0, score retained. start_press during OVER is ignored.
- Assert rst mid-HIT, asynchronously between clock edges -> all outputs at reset values before the next edge.
- With SEQ_PAUSE_EN, press start in PLAY -> game_en=0 and frame ticks ignored. Press again -> PLAY with no clear_field.

Source files
------------

// File: rtl/game_sequencer.sv
// game_sequencer: phase controller for the shooting game core.
// Debounces start_btn, derives frame ticks from vsync, and sequences
// ATTRACT -> PLAY -> HIT/OVER while tracking lives and score.
// Optional build macro: SEQ_PAUSE_EN (start_press toggles PLAY <-> PAUSE).
module game_sequencer #(
  parameter int unsigned LIVES           = 3,
  parameter int unsigned SCORE_W         = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned HIT_FRAMES      = 60,
  parameter int unsigned OVER_FRAMES     = 180
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_btn,
  input  logic               vsync,
  input  logic               hit_player,
  input  logic               hit_enemy,
  output logic [1:0]         phase,
  output logic               game_en,
  output logic               clear_field,
  output logic [2:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic               game_over
);

  localparam int unsigned FRAME_MAX = (HIT_FRAMES > OVER_FRAMES) ? HIT_FRAMES : OVER_FRAMES;
  localparam int unsigned FRAME_W   = $clog2(FRAME_MAX + 1);
  localparam int unsigned DB_W      = $clog2(DEBOUNCE_CYCLES);

  localparam logic [2:0]         LIVES_INIT = 3'(LIVES);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
  localparam logic [FRAME_W-1:0] HIT_LAST   = FRAME_W'(HIT_FRAMES - 1);
  localparam logic [FRAME_W-1:0] OVER_LAST  = FRAME_W'(OVER_FRAMES - 1);
  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);

  // Low two bits of the state code are the phase presented on the port.
  typedef enum logic [2:0] {
    ST_ATTRACT = 3'b000,
    ST_PLAY    = 3'b001,
    ST_HIT     = 3'b010,
    ST_OVER    = 3'b011,
    ST_PAUSE   = 3'b110
  } state_t;

  state_t               state_q;
  logic                 sync1_q, sync2_q;
  logic                 deb_q;
  logic [DB_W-1:0]      db_cnt_q;
  logic                 start_press_q;
  logic                 vsync_q;
  logic                 frame_tick_c;
  logic [FRAME_W-1:0]   frame_cnt_q;
  logic                 game_en_q, clear_field_q, game_over_q;
  logic [2:0]           lives_q;
  logic [SCORE_W-1:0]   score_q;

  // Synchronise and debounce start_btn; pulse start_press on accepted press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      deb_q         <= 1'b0;
      db_cnt_q      <= '0;
      start_press_q <= 1'b0;
    end else begin
      sync1_q       <= start_btn;
      sync2_q       <= sync1_q;
      start_press_q <= 1'b0;
      if (sync2_q == deb_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_LAST) begin
        deb_q         <= sync2_q;
        db_cnt_q      <= '0;
        start_press_q <= sync2_q;
      end else begin
        db_cnt_q <= db_cnt_q + DB_W'(1);
      end
    end
  end

  // vsync delay register; tick marks the end of the active-low sync pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vsync_q <= 1'b1;
    else     vsync_q <= vsync;
  end

  assign frame_tick_c = vsync & ~vsync_q;

  // Phase sequencer with registered engine controls, lives and score.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_ATTRACT;
      game_en_q     <= 1'b0;
      clear_field_q <= 1'b0;
      game_over_q   <= 1'b0;
      lives_q       <= LIVES_INIT;
      score_q       <= '0;
      frame_cnt_q   <= '0;
    end else begin
      clear_field_q <= 1'b0;
      case (state_q)
        ST_ATTRACT: begin
          if (start_press_q) begin
            state_q       <= ST_PLAY;
            game_en_q     <= 1'b1;
            clear_field_q <= 1'b1;
            lives_q       <= LIVES_INIT;
            score_q       <= '0;
          end
        end
        ST_PLAY: begin
          if (hit_enemy && (score_q != SCORE_MAX)) score_q <= score_q + SCORE_W'(1);
          if (hit_player) begin
            game_en_q   <= 1'b0;
            frame_cnt_q <= '0;
            if (lives_q > 3'd1) begin
              lives_q <= lives_q - 3'd1;
              state_q <= ST_HIT;
            end else begin
              lives_q     <= 3'd0;
              state_q     <= ST_OVER;
              game_over_q <= 1'b1;
            end
          end
`ifdef SEQ_PAUSE_EN
          else if (start_press_q) begin
            state_q   <= ST_PAUSE;
            game_en_q <= 1'b0;
          end
`endif
        end
        ST_HIT: begin
          if (frame_tick_c) begin
            if (frame_cnt_q == HIT_LAST) begin
              state_q       <= ST_PLAY;
              game_en_q     <= 1'b1;
              clear_field_q <= 1'b1;
              frame_cnt_q   <= '0;
            end else begin
              frame_cnt_q <= frame_cnt_q + FRAME_W'(1);
            end
          end
        end
        ST_OVER: begin
          if (frame_tick_c) begin
            if (frame_cnt_q == OVER_LAST) begin
              state_q     <= ST_ATTRACT;
              game_over_q <= 1'b0;
              frame_cnt_q <= '0;
            end else begin
              frame_cnt_q <= frame_cnt_q + FRAME_W'(1);
            end
          end
        end
`ifdef SEQ_PAUSE_EN
        ST_PAUSE: begin
          if (start_press_q) begin
            state_q   <= ST_PLAY;
            game_en_q <= 1'b1;
          end
        end
`endif
        default: begin
          state_q   <= ST_ATTRACT;
          game_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign phase       = state_q[1:0];
  assign game_en     = game_en_q;
  assign clear_field = clear_field_q;
  assign game_over   = game_over_q;
  assign lives       = lives_q;
  assign score       = score_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: every change of the observed output
// tuple is an event that must match the next queued expectation.
module tb_game_sequencer;

  logic clk, rst, start_btn, vsync, hit_player, hit_enemy;
  logic [1:0]  phase;
  logic        game_en, clear_field, game_over;
  logic [2:0]  lives;
  logic [15:0] score;

  logic [1:0]  s_phase;
  logic        s_game_en, s_clear_field, s_game_over;
  logic [2:0]  s_lives;
  logic [2:0]  s_score;

  typedef struct packed {
    logic [1:0]  phase;
    logic [2:0]  lives;
    logic [15:0] score;
    logic        en;
    logic        over;
    logic        clr;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;
  bit   primed = 0;
  obs_t prev_o;

  game_sequencer #(.LIVES(2), .SCORE_W(16), .DEBOUNCE_CYCLES(4),
                   .HIT_FRAMES(2), .OVER_FRAMES(3)) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .vsync(vsync),
    .hit_player(hit_player), .hit_enemy(hit_enemy),
    .phase(phase), .game_en(game_en), .clear_field(clear_field),
    .lives(lives), .score(score), .game_over(game_over));

  game_sequencer #(.LIVES(2), .SCORE_W(3), .DEBOUNCE_CYCLES(4),
                   .HIT_FRAMES(2), .OVER_FRAMES(3)) dut_s (
    .clk(clk), .rst(rst), .start_btn(start_btn), .vsync(vsync),
    .hit_player(hit_player), .hit_enemy(hit_enemy),
    .phase(s_phase), .game_en(s_game_en), .clear_field(s_clear_field),
    .lives(s_lives), .score(s_score), .game_over(s_game_over));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t cur_obs();
    obs_t o;
    o.phase = phase;
    o.lives = lives;
    o.score = score;
    o.en    = game_en;
    o.over  = game_over;
    o.clr   = clear_field;
    return o;
  endfunction

  task automatic push(input logic [1:0] ph, input logic [2:0] lv, input logic [15:0] sc,
                      input logic en, input logic ov, input logic cl);
    obs_t o;
    o.phase = ph; o.lives = lv; o.score = sc; o.en = en; o.over = ov; o.clr = cl;
    exp_q.push_back(o);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: any output change pops and compares the next expectation.
  always @(negedge clk) begin
    obs_t cur, e;
    if (mon_en) begin
      cur = cur_obs();
      if (!primed) begin
        prev_o = cur;
        primed = 1'b1;
      end else if (cur !== prev_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event got ph=%0d lv=%0d sc=%0d en=%0b ov=%0b clr=%0b",
                   cur.phase, cur.lives, cur.score, cur.en, cur.over, cur.clr);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            errors++;
            $display("FAIL event got ph=%0d lv=%0d sc=%0d en=%0b ov=%0b clr=%0b expected ph=%0d lv=%0d sc=%0d en=%0b ov=%0b clr=%0b",
                     cur.phase, cur.lives, cur.score, cur.en, cur.over, cur.clr,
                     e.phase, e.lives, e.score, e.en, e.over, e.clr);
          end
        end
        prev_o = cur;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_start();
    start_btn = 1'b1; tick(10);
    start_btn = 1'b0; tick(10);
  endtask

  task automatic pulse_enemy();
    hit_enemy = 1'b1; tick(1);
    hit_enemy = 1'b0; tick(1);
  endtask

  task automatic pulse_player();
    hit_player = 1'b1; tick(1);
    hit_player = 1'b0; tick(1);
  endtask

  task automatic vsync_pulse();
    vsync = 1'b0; tick(2);
    vsync = 1'b1; tick(2);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start_btn = 1'b0; vsync = 1'b1; hit_player = 1'b0; hit_enemy = 1'b0;
    tick(3);
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_game_en", 32'(game_en), 32'd0);
    check("rst_clear", 32'(clear_field), 32'd0);
    check("rst_lives", 32'(lives), 32'd2);
    check("rst_score", 32'(score), 32'd0);
    check("rst_over", 32'(game_over), 32'd0);
    rst = 1'b0;
    tick(2);
    mon_en = 1'b1;
    tick(2);

    // 3-cycle glitch must not be accepted
    start_btn = 1'b1; tick(3);
    start_btn = 1'b0; tick(10);

    // Game start
    push(2'd1, 3'd2, 16'd0, 1'b1, 1'b0, 1'b1);
    push(2'd1, 3'd2, 16'd0, 1'b1, 1'b0, 1'b0);
    press_start();

    // Scoring, including saturation in the narrow instance
    for (int i = 1; i <= 5; i++) push(2'd1, 3'd2, 16'(i), 1'b1, 1'b0, 1'b0);
    repeat (5) pulse_enemy();
    check("score5_narrow", 32'(s_score), 32'd5);
    for (int i = 6; i <= 9; i++) push(2'd1, 3'd2, 16'(i), 1'b1, 1'b0, 1'b0);
    repeat (4) pulse_enemy();
    check("score_sat_narrow", 32'(s_score), 32'd7);

    // Player hit -> HIT, enemy hits ignored, two frames -> PLAY + clear
    push(2'd2, 3'd1, 16'd9, 1'b0, 1'b0, 1'b0);
    pulse_player();
    pulse_enemy();
    vsync_pulse();
    push(2'd1, 3'd1, 16'd9, 1'b1, 1'b0, 1'b1);
    push(2'd1, 3'd1, 16'd9, 1'b1, 1'b0, 1'b0);
    vsync_pulse();
    tick(2);

    // Simultaneous hits on last life -> OVER with score+1
    push(2'd3, 3'd0, 16'd10, 1'b0, 1'b1, 1'b0);
    hit_player = 1'b1; hit_enemy = 1'b1; tick(1);
    hit_player = 1'b0; hit_enemy = 1'b0; tick(1);
    press_start();
    vsync_pulse();
    vsync_pulse();
    push(2'd0, 3'd0, 16'd10, 1'b0, 1'b0, 1'b0);
    vsync_pulse();
    tick(2);

    // New game, enter HIT, then async reset between edges
    push(2'd1, 3'd2, 16'd0, 1'b1, 1'b0, 1'b1);
    push(2'd1, 3'd2, 16'd0, 1'b1, 1'b0, 1'b0);
    press_start();
    push(2'd2, 3'd1, 16'd0, 1'b0, 1'b0, 1'b0);
    pulse_player();
    vsync_pulse();
    push(2'd0, 3'd2, 16'd0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("async_phase", 32'(phase), 32'd0);
    check("async_lives", 32'(lives), 32'd2);
    check("async_game_en", 32'(game_en), 32'd0);
    check("async_clear", 32'(clear_field), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(3);

    // start_press while playing
    push(2'd1, 3'd2, 16'd0, 1'b1, 1'b0, 1'b1);
    push(2'd1, 3'd2, 16'd0, 1'b1, 1'b0, 1'b0);
    press_start();
`ifdef SEQ_PAUSE_EN
    push(2'd2, 3'd2, 16'd0, 1'b0, 1'b0, 1'b0);
    press_start();
    repeat (3) vsync_pulse();
    pulse_player();
    pulse_enemy();
    push(2'd1, 3'd2, 16'd0, 1'b1, 1'b0, 1'b0);
    press_start();
`else
    press_start();
    repeat (3) vsync_pulse();
`endif
    tick(5);

    check("events_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
